ram_write_seq: RTL
==================

// Module: ram_write_seq
// PURPOSE
//  Write-side sequencer placed directly upstream of the dual-clock ram write port.
//  Accepts a byte stream over a valid/ready handshake and turns it into a burst of
//  writes at consecutive addresses. Drives address_write/data_write/write_enable.
//  Signals burst completion to the control logic.
// PARAMETERS
//  ADDR_W  5  write address width; DEPTH = 2**ADDR_W words (local, 32)
//  DATA_W  8  data width; matches the ram data_write width
// PORTS
//  clk_write      in   1         sole clock; all state updates on its rising edge
//  reset          in   1         asynchronous, active-high; clears all state
//  start          in   1         1-cycle request to begin a burst (sampled in IDLE only)
//  start_addr     in   ADDR_W    first write address of the burst
//  burst_len      in   ADDR_W+1  beats in the burst; 0 means DEPTH (32)
//  abort          in   1         cancel the burst in progress
//  in_valid       in   1         upstream byte valid
//  in_data        in   DATA_W    upstream byte
//  in_ready       out  1         sequencer accepts in_data this cycle
//  address_write  out  ADDR_W    to ram address_write (registered)
//  data_write     out  DATA_W    to ram data_write (registered)
//  write_enable   out  1         to ram write_enable (registered, 1 cycle per beat)
//  busy           out  1         state != IDLE
//  done           out  1         1-cycle pulse, coincides with the last write_enable
//  beats_done     out  ADDR_W+1  beats accepted in current/last burst
// BEHAVIOUR
//  - Reset (async): state=IDLE; every output = 0. Reset during a burst drops
//    write_enable immediately. No done pulse is issued.
//  - States: IDLE -> RUN -> LAST -> IDLE.
//    IDLE: in_ready=0. On start=1, latch cur_addr=start_addr and
//      remaining=(burst_len==0 ? DEPTH : burst_len). Clear beats_done. Go to RUN.
//    RUN: in_ready = ~abort (combinational from state and abort).
//      A beat is accepted when in_valid & in_ready.
//      On accept: cur_addr <= cur_addr+1 mod DEPTH (31 wraps to 0).
//        Also remaining--, beats_done++.
//      Accepting with remaining==1 -> LAST.
//      abort=1 -> IDLE on the next edge, no done. A beat presented alongside
//        abort is not accepted. Writes already registered still complete.
//    LAST: in_ready=0, done=1 for this one cycle, then IDLE.
//  - Latency: a beat accepted at edge k gives write_enable=1 during the cycle after
//    edge k, with address_write=address of that beat and data_write=in_data at k.
//    Back-to-back accepts give continuous write_enable. Each bubble on in_valid
//    gives write_enable=0 for one cycle.
//  - address_write/data_write hold their last values when write_enable=0.
//  - start while busy is ignored. start and abort together in IDLE: start wins,
//    abort is ignored.
//  - A burst of DEPTH beats starting at address a writes a..31, 0..a-1 exactly once.
//  - beats_done saturates naturally at DEPTH and holds until the next start.
// STRUCTURE
//  - ram_defs.vh (shared with ram and its benches): ADDR_W, DATA_W, DEPTH defaults;
//    state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_LAST=2'd2.
//  - Sub-module ram_addr_counter: loadable wrapping ADDR_W counter (load, inc, value).
//    Used for cur_addr.
//  - FSM, remaining/beats_done counters and the output register stage stay in this
//    module.
// TESTING (bench instantiates ram_write_seq + ram; reads back through the ram read port)
//  1 start_addr=5'h1B, burst_len=1, in_data=8'hC5 valid -> one write_enable;
//    done with it; ram[1B]==C5.
//  2 start_addr=5'h1E, burst_len=4, data 01..04 continuous -> addresses 1E,1F,00,01;
//    4 consecutive write_enable cycles; beats_done=4.
//  3 burst_len=0 from addr 0, 32 bytes -> all 32 locations written once;
//    done after 32nd write; busy low the cycle after.
//  4 burst_len=3, in_valid pattern 1,0,1,1 -> write_enable pattern 1,0,1,1;
//    addresses contiguous.
//  5 burst_len=8, abort after 3 beats (in_valid high with abort) -> exactly 3 writes;
//    done never pulses; IDLE the next cycle.
//  6 reset asserted mid-burst between edges -> write_enable/busy/in_ready drop at once;
//    later start works normally.

Source files
------------

// File: rtl/ram_write_seq_pkg.sv
// ram_write_seq_pkg: shared widths, lengths and FSM state encoding for the ram write sequencer
package ram_write_seq_pkg;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;
   localparam int DEPTH = 1 << ADDR_W;
   typedef logic [ADDR_W:0] len_t;
   localparam len_t ONE = len_t'(1);
   localparam len_t DEPTH_LEN = len_t'(DEPTH);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_LAST = 2'd2
   } state_t;
endpackage

// File: rtl/ram_write_seq_if.sv
// ram_write_seq_if: valid/ready byte stream feeding the write sequencer
interface ram_write_seq_if;
   import ram_write_seq_pkg::*;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   modport master (output in_valid, in_data, input in_ready);
   modport slave (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/ram_write_seq_addr_counter.sv
// ram_write_seq_addr_counter: loadable wrapping address counter
module ram_write_seq_addr_counter #(
   parameter int W = 5
) (
   input  logic         clk_write,
   input  logic         reset,
   input  logic         load,
   input  logic         inc,
   input  logic [W-1:0] load_value,
   output logic [W-1:0] value
);
   always_ff @(posedge clk_write or posedge reset)
      if (reset) value <= '0;
      else if (load) value <= load_value;
      else if (inc) value <= value + W'(1);
endmodule

// File: rtl/ram_write_seq.sv
// ram_write_seq: turns a byte stream into a burst of registered ram writes at consecutive addresses
module ram_write_seq
   import ram_write_seq_pkg::*;
(
   input  logic              clk_write,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  len_t              burst_len,
   input  logic              abort,
   ram_write_seq_if.slave    s,
   output logic [ADDR_W-1:0] address_write,
   output logic [DATA_W-1:0] data_write,
   output logic              write_enable,
   output logic              busy,
   output logic              done,
   output len_t              beats_done
);
   state_t            state;
   len_t              remaining;
   logic [ADDR_W-1:0] cur_addr;
   logic              accept;
   logic              load;
   assign s.in_ready = state == ST_RUN && !abort;
   assign accept = s.in_valid && s.in_ready;
   assign load = state == ST_IDLE && start;
   assign busy = state != ST_IDLE;
   ram_write_seq_addr_counter #(.W(ADDR_W)) u_addr (
      .clk_write (clk_write),
      .reset     (reset),
      .load      (load),
      .inc       (accept),
      .load_value(start_addr),
      .value     (cur_addr)
   );
   // done is registered with the last beat so it lines up with its write_enable
   always_ff @(posedge clk_write or posedge reset)
      if (reset) begin
         state <= ST_IDLE;
         remaining <= '0;
         beats_done <= '0;
         address_write <= '0;
         data_write <= '0;
         write_enable <= 1'b0;
         done <= 1'b0;
      end else begin
         write_enable <= accept;
         done <= accept && remaining == ONE;
         if (accept) begin
            address_write <= cur_addr;
            data_write <= s.in_data;
            remaining <= remaining - ONE;
            beats_done <= beats_done + ONE;
         end
         case (state)
            ST_IDLE: if (start) begin
               state <= ST_RUN;
               remaining <= burst_len == '0 ? DEPTH_LEN : burst_len;
               beats_done <= '0;
            end
            ST_RUN: if (abort) state <= ST_IDLE;
               else if (accept && remaining == ONE) state <= ST_LAST;
            default: state <= ST_IDLE;
         endcase
      end
endmodule
